// File: rtl/r_type_issue.sv
// r_type_issue: serial RV32 R-type issue stage with internal regfile, 4-cycle IDLE/DECODE/EXEC/WB sequence
module r_type_issue #(
  parameter bit ZERO_HARDWIRED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [31:0] In1,
  output logic [31:0] In2,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  input  logic [31:0] Result,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        illegal,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata
);
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
  state_t state;
  logic [31:0] instr_q, op1_q, op2_q, res_q;
  logic [31:0] rf [32];
  logic [4:0] rs1, rs2, rd;
  function automatic logic is_legal(input logic [31:0] i);
    return i[6:0] == 7'b0110011 &&
           (i[31:25] == 7'b0000000 ||
            (i[31:25] == 7'b0100000 && (i[14:12] == 3'b000 || i[14:12] == 3'b101)));
  endfunction
  function automatic logic [31:0] read_reg(input logic [4:0] a);
    return (ZERO_HARDWIRED && a == 5'd0) ? 32'd0 : rf[a];
  endfunction
  assign rs1         = instr_q[19:15];
  assign rs2         = instr_q[24:20];
  assign rd          = instr_q[11:7];
  assign instr_ready = state == IDLE;
  assign In1         = op1_q;
  assign In2         = op2_q;
  assign opcode      = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign funct7      = instr_q[31:25];
  assign wb_rd       = rd;
  assign wb_data     = res_q;
  assign dbg_rdata   = read_reg(dbg_addr);
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      instr_q  <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      res_q    <= '0;
      wb_valid <= 1'b0;
      illegal  <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      wb_valid <= 1'b0;
      illegal  <= 1'b0;
      unique case (state)
        IDLE: begin
          // debug write lands before the accepted instruction's DECODE read
          if (dbg_we && !(ZERO_HARDWIRED && dbg_addr == 5'd0)) rf[dbg_addr] <= dbg_wdata;
          if (instr_valid) begin
            instr_q <= instr;
            illegal <= !is_legal(instr);
            state   <= DECODE;
          end
        end
        DECODE: begin
          if (is_legal(instr_q)) begin
            op1_q <= read_reg(rs1);
            op2_q <= read_reg(rs2);
            state <= EXEC;
          end else state <= IDLE;
        end
        EXEC: begin
          res_q    <= Result;
          wb_valid <= 1'b1;
          state    <= WB;
        end
        WB: begin
          if (!(ZERO_HARDWIRED && rd == 5'd0)) rf[rd] <= res_q;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_r_type_issue.sv
// tb_r_type_issue: directed plus randomized checks of r_type_issue against a regfile/ALU model
module tb_r_type_issue;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready;
  logic [31:0] In1, In2, Result, wb_data, dbg_rdata;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        wb_valid, illegal;
  logic [4:0]  wb_rd;
  logic        dbg_we = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  int n = 0;
  int fails = 0;
  logic [31:0] m_rf [32];
  r_type_issue dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .In1(In1), .In2(In2), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .Result(Result), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] alu(input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return f7[5] ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction
  always_comb Result = alu(funct3, funct7, In1, In2);
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic rd_chk(input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk($sformatf("dbg_x%0d", a), dbg_rdata, exp);
  endtask
  task automatic dbg_wr(input logic [4:0] a, input logic [31:0] d);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    tick();
    dbg_we = 1'b0;
    if (a != 0) m_rf[a] = d;
  endtask
  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                     input logic [2:0] f3, input logic [4:0] rdd, input logic [6:0] op);
    return {f7, r2, r1, f3, rdd, op};
  endfunction
  task automatic issue(input logic [31:0] ins, input bit co, input bit junk);
    logic lg;
    logic [31:0] a, b, r;
    logic [4:0] rdd;
    lg = ins[6:0] == 7'h33 && (ins[31:25] == 7'h00 ||
         (ins[31:25] == 7'h20 && (ins[14:12] == 3'd0 || ins[14:12] == 3'd5)));
    rdd = ins[11:7];
    if (co) begin
      dbg_we = 1'b1; dbg_addr = 5'($urandom); dbg_wdata = $urandom;
      if (dbg_addr != 0) m_rf[dbg_addr] = dbg_wdata;
    end
    instr = ins; instr_valid = 1'b1;
    chk("ready_idle", 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 1'b0; instr = $urandom;
    dbg_we = junk; dbg_addr = 5'($urandom); dbg_wdata = $urandom;
    chk("illegal_decode", 32'(illegal), 32'(!lg));
    chk("wb_valid_decode", 32'(wb_valid), 32'd0);
    chk("ready_decode", 32'(instr_ready), 32'd0);
    if (!lg) begin
      tick();
      dbg_we = 1'b0;
      chk("illegal_after", 32'(illegal), 32'd0);
      chk("ready_after_illegal", 32'(instr_ready), 32'd1);
      chk("wb_valid_after_illegal", 32'(wb_valid), 32'd0);
      return;
    end
    a = m_rf[ins[19:15]];
    b = m_rf[ins[24:20]];
    r = alu(ins[14:12], ins[31:25], a, b);
    tick();
    chk("in1", In1, a);
    chk("in2", In2, b);
    chk("funct7_exec", 32'(funct7), 32'(ins[31:25]));
    chk("wb_valid_exec", 32'(wb_valid), 32'd0);
    chk("ready_exec", 32'(instr_ready), 32'd0);
    tick();
    chk("wb_valid", 32'(wb_valid), 32'd1);
    chk("wb_rd", 32'(wb_rd), 32'(rdd));
    chk("wb_data", wb_data, r);
    chk("illegal_wb", 32'(illegal), 32'd0);
    chk("ready_wb", 32'(instr_ready), 32'd0);
    tick();
    dbg_we = 1'b0;
    chk("wb_valid_end", 32'(wb_valid), 32'd0);
    chk("ready_end", 32'(instr_ready), 32'd1);
    if (rdd != 0) m_rf[rdd] = r;
  endtask
  initial begin
    logic [31:0] e;
    logic [2:0] f3;
    logic [6:0] f7, op;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_in1", In1, 32'd0);
    chk("rst_in2", In2, 32'd0);
    chk("rst_fields", {15'd0, opcode, funct3, funct7}, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    for (int i = 0; i < 32; i++) rd_chk(5'(i), 32'd0);
    dbg_wr(5'd1, 32'd5);
    dbg_wr(5'd2, 32'd3);
    issue(32'h002081B3, 1'b0, 1'b0);
    rd_chk(5'd3, 32'd8);
    issue(32'h40208233, 1'b0, 1'b1);
    rd_chk(5'd4, 32'd2);
    issue(32'h00208033, 1'b0, 1'b0);
    rd_chk(5'd0, 32'd0);
    issue(32'h00508093, 1'b0, 1'b0);
    issue(32'h40209033, 1'b0, 1'b1);
    rd_chk(5'd1, 32'd5);
    dbg_wr(5'd0, 32'hDEADBEEF);
    rd_chk(5'd0, 32'd0);
    // back-to-back with instr_valid held; second reads the first's result
    instr = 32'h002081B3; instr_valid = 1'b1;
    tick();
    instr = mk(7'h00, 5'd1, 5'd3, 3'd0, 5'd5, 7'h33);
    chk("b2b_ready1", 32'(instr_ready), 32'd0);
    tick();
    chk("b2b_ready2", 32'(instr_ready), 32'd0);
    tick();
    chk("b2b_ready3", 32'(instr_ready), 32'd0);
    chk("b2b_wb1", 32'(wb_valid), 32'd1);
    chk("b2b_data1", wb_data, 32'd8);
    tick();
    chk("b2b_ready4", 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 1'b0;
    chk("b2b_second_accepted", 32'(instr_ready), 32'd0);
    tick(); tick();
    chk("b2b_wb2", 32'(wb_valid), 32'd1);
    chk("b2b_data2", wb_data, 32'd13);
    tick();
    m_rf[5] = 32'd13;
    rd_chk(5'd5, 32'd13);
    for (int i = 1; i < 32; i++) dbg_wr(5'(i), $urandom);
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1, 2: f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      f3 = 3'($urandom);
      op = ($urandom_range(0, 7) == 0) ? 7'h13 : 7'h33;
      if (k % 4 == 0) f7 = 7'h00;
      issue(mk(f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), op),
            1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 32; i++) rd_chk(5'(i), m_rf[i]);
    // reset while EXEC is in flight
    instr = mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd6, 7'h33); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_exec_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_exec_illegal", 32'(illegal), 32'd0);
    chk("rst_exec_ready", 32'(instr_ready), 32'd1);
    tick();
    chk("rst_exec_wb_valid2", 32'(wb_valid), 32'd0);
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    rd_chk(5'd6, 32'd0);
    rd_chk(5'd1, 32'd0);
    issue(mk(7'h00, 5'd0, 5'd0, 3'd0, 5'd7, 7'h33), 1'b1, 1'b0);
    for (int i = 0; i < 32; i++) rd_chk(5'(i), m_rf[i]);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule

// File: doc/r_type_issue.md
R_TYPE_ISSUE -- requirements
Module: r_type_issue

Interface
REQ-001 Parameter ZERO_HARDWIRED, default 1: when 1, x0 reads as zero and writes to x0 are discarded.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 instr_valid  in  1  upstream instruction valid.
REQ-006 instr  in  32  RV32 instruction word.
REQ-007 instr_ready  out  1  block can accept an instruction.
REQ-008 In1  out  32  ALU operand 1, the rs1 value.
REQ-009 In2  out  32  ALU operand 2, the rs2 value.
REQ-010 opcode  out  7  to ALU, instr[6:0].
REQ-011 funct3  out  3  to ALU, instr[14:12].
REQ-012 funct7  out  7  to ALU, instr[31:25].
REQ-013 Result  in  32  combinational ALU result.
REQ-014 wb_valid  out  1  one-cycle writeback pulse.
REQ-015 wb_rd  out  5  writeback destination index.
REQ-016 wb_data  out  32  writeback value.
REQ-017 illegal  out  1  one-cycle pulse marking a rejected instruction.
REQ-018 dbg_we  in  1  debug register write strobe.
REQ-019 dbg_addr  in  5  debug read/write index.
REQ-020 dbg_wdata  in  32  debug write data.
REQ-021 dbg_rdata  out  32  combinational read of regfile[dbg_addr]; reads 0 when dbg_addr=0 and ZERO_HARDWIRED=1.

Function
REQ-022 Register file: 32 entries of 32 bits, internal to the block.
REQ-023 FSM states and transitions:
- IDLE -> DECODE on instr_valid&&instr_ready; the instr word is captured into instr_q.
- DECODE -> EXEC if legal, else -> IDLE.
- EXEC -> WB.
- WB -> IDLE.
REQ-024 instr_ready is 1 only in IDLE; instr is ignored in every other state.
REQ-025 Legal instruction: opcode=0110011 with funct7=0000000 (any funct3), or funct7=0100000 with funct3 in {000,101}; every other encoding is illegal.
REQ-026 DECODE, legal: register regfile[rs1] into op1_q and regfile[rs2] into op2_q.
REQ-027 DECODE, illegal: illegal=1 for exactly that cycle; no writeback; no register change.
REQ-028 In1/In2 are driven from op1_q/op2_q; opcode/funct3/funct7 are driven from instr_q fields in all states.
REQ-029 EXEC: Result is registered into res_q at the end of the cycle.
REQ-030 WB: wb_valid=1, wb_rd=instr_q[11:7], wb_data=res_q, all for exactly one cycle.
REQ-031 WB register write: regfile[rd]<=res_q, except when rd=0 and ZERO_HARDWIRED=1 (wb_valid still pulses).
REQ-032 Latency: accept edge at cycle N; wb_valid is high in cycle N+3. Throughput: one instruction per 4 cycles.
REQ-033 Instructions are strictly serialized: a following instruction's DECODE read observes the prior WB write (no forwarding logic needed).
REQ-034 dbg_we is honoured only in IDLE and ignored in other states. If dbg_we and an accept coincide, the debug write occurs first and the accepted instruction's DECODE sees it.
REQ-035 wb_valid and illegal are never both high in the same cycle.

Reset
REQ-036 On reset: state=IDLE, instr_ready=1, wb_valid=0, illegal=0, wb_rd=0, wb_data=0; instr_q, op1_q, op2_q and res_q are cleared, so In1=In2=0 and opcode=funct3=funct7=0.
REQ-037 On reset: all 32 register-file entries are cleared to 0.
REQ-038 Reset in any state (including mid-EXEC) abandons the instruction: no wb_valid or illegal pulse follows, and instr_ready=1 on the next cycle.

Verification
REQ-039 Reset, then sweep dbg_addr 0..31 -> dbg_rdata=0 for all 32, instr_ready=1.
REQ-040 dbg write x1=5, x2=3, then issue 0x002081B3 (add x3,x1,x2) accepted at cycle N -> wb_valid in N+3, wb_rd=3, wb_data=8, dbg x3=8; instr_ready=0 during N+1..N+3.
REQ-041 Issue 0x40208233 (sub x4,x1,x2) with x1=5, x2=3 -> funct7=0100000 on ALU port during EXEC, wb_data=2, x4=2.
REQ-042 Issue 0x00208033 (add x0,x1,x2) -> wb_valid pulses with wb_rd=0, wb_data=8; dbg x0 still reads 0.
REQ-043 Issue 0x00508093 (addi), then 0x40209033 (funct7=0100000, funct3=001) -> illegal pulse in N+1 for each; no wb_valid; x1 unchanged at 5.
REQ-044 Hold instr_valid=1 continuously with two adds -> second accepted exactly 4 cycles after the first. Assert reset during EXEC of an add -> no wb_valid follows, destination reads 0.
